// File: rtl/dbus_sram_responder.sv
// Word-organised SRAM target for the core dBus: one command outstanding, one response each.
// Response 1+WAIT_STATES cycles after accept; cmd_ready is low from accept until the response issues.
module dbus_sram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic [31:0] dBus_cmd_payload_addr,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [3:0]  dBus_cmd_payload_size,
  input  logic        dBus_cmd_payload_wr,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_valid,
  output logic        dBus_rsp_error
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_next;
  logic [3:0]     wait_cnt, wait_cnt_next;
  logic           accept;
  logic [31:0]    offset;
  logic           size_ok, align_ok, range_ok;

  logic [AW-1:0]  idx_q;
  logic [1:0]     lane_q;
  logic [31:0]    data_q;
  logic [3:0]     size_q;
  logic           wr_q, err_q;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    wdata, rshift, rdata;
  logic [3:0]     wmask;

  assign accept   = dBus_cmd_valid && dBus_cmd_ready;
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign offset   = dBus_cmd_payload_addr - BASE_ADDR;
  assign range_ok = {1'b0, offset} < SPAN;

  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b0;
    case (dBus_cmd_payload_size)
      4'b0001: begin size_ok = 1'b1; align_ok = 1'b1; end
      4'b0011: begin size_ok = 1'b1; align_ok = !dBus_cmd_payload_addr[0]; end
      4'b1111: begin size_ok = 1'b1; align_ok = (dBus_cmd_payload_addr[1:0] == 2'b00); end
      default: begin size_ok = 1'b0; align_ok = 1'b0; end
    endcase
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_next = S_RESP;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      wait_cnt       <= 4'd0;
      dBus_cmd_ready <= 1'b0;
    end else begin
      state          <= state_next;
      wait_cnt       <= wait_cnt_next;
      dBus_cmd_ready <= (state_next == S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      lane_q <= 2'b00;
      data_q <= 32'h0;
      size_q <= 4'h0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      idx_q  <= offset[AW+1:2];
      lane_q <= dBus_cmd_payload_addr[1:0];
      data_q <= dBus_cmd_payload_data;
      size_q <= dBus_cmd_payload_size;
      wr_q   <= dBus_cmd_payload_wr;
      err_q  <= !(size_ok && align_ok && range_ok);
    end
  end

  assign wdata  = data_q << {lane_q, 3'b000};
  assign wmask  = size_q << lane_q;
  assign rshift = mem[idx_q] >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      4'b0001: rdata = {24'h0, rshift[7:0]};
      4'b0011: rdata = {16'h0, rshift[15:0]};
      default: rdata = rshift;
    endcase
  end

  // Commit happens on the edge leaving RESP; reset forces IDLE, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (state == S_RESP && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dBus_rsp_valid <= 1'b0;
      dBus_rsp_error <= 1'b0;
      dBus_rsp_data  <= 32'h0;
    end else begin
      dBus_rsp_valid <= (state == S_RESP);
      dBus_rsp_error <= (state == S_RESP) && err_q;
      dBus_rsp_data  <= (state == S_RESP && !err_q && !wr_q) ? rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three configurations, byte-level memory model, response scoreboard.
module tb_dbus_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid [3];
  logic [31:0] cmd_addr  [3];
  logic [31:0] cmd_data  [3];
  logic [3:0]  cmd_size  [3];
  logic        cmd_wr    [3];
  logic        cmd_ready [3];
  logic        rsp_valid [3];
  logic        rsp_error [3];
  logic [31:0] rsp_data  [3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : ((k == 1) ? 256 : 16);
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h1000_0000 : 32'h0000_0000;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dbus_sram_responder #(
      .DEPTH_WORDS(depth_of(g)),
      .BASE_ADDR  (base_of(g)),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .dBus_cmd_valid       (cmd_valid[g]),
      .dBus_cmd_ready       (cmd_ready[g]),
      .dBus_cmd_payload_addr(cmd_addr[g]),
      .dBus_cmd_payload_data(cmd_data[g]),
      .dBus_cmd_payload_size(cmd_size[g]),
      .dBus_cmd_payload_wr  (cmd_wr[g]),
      .dBus_rsp_data        (rsp_data[g]),
      .dBus_rsp_valid       (rsp_valid[g]),
      .dBus_rsp_error       (rsp_error[g])
    );
  end

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic [1:0]  inst;
    logic [31:0] cyc;
  } sb_t;

  sb_t         sbq  [$];
  string       tagq [$];
  logic [7:0]  mdl  [longint];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          last_wait = 0;
  int          a_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
  endtask

  // Byte-addressed reference: applies the access rules directly to individual bytes.
  task automatic model(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit commit,
                       output logic [31:0] ed, output logic ee);
    logic [31:0] off;
    int          nb;
    longint      key;
    off = a - base_of(k);
    case (s)
      4'b0001: nb = 1;
      4'b0011: nb = 2;
      4'b1111: nb = 4;
      default: nb = 0;
    endcase
    ee = (nb == 0) || (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00) ||
         (longint'(off) >= longint'(depth_of(k)) * 4);
    ed = 32'h0;
    if (!ee) begin
      for (int b = 0; b < nb; b++) begin
        key = (longint'(k) << 32) + longint'(off) + longint'(b);
        if (w) begin
          if (commit) mdl[key] = d[8*b +: 8];
        end else begin
          ed[8*b +: 8] = mdl.exists(key) ? mdl[key] : 8'h00;
        end
      end
    end
  endtask

  // Presents a command and returns just after the accepting edge; valid stays high until idle().
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag, input bit want_rsp = 1'b1);
    logic [31:0] ed;
    logic        ee;
    sb_t         e;
    int          n;
    @(negedge clk);
    cmd_valid[k] = 1'b1;
    cmd_wr[k]    = w;
    cmd_addr[k]  = a;
    cmd_data[k]  = d;
    cmd_size[k]  = s;
    n = 0;
    while (cmd_ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (cmd_ready[k] !== 1'b1) begin
      check_eq({tag, "_accept_timeout"}, 32'(cmd_ready[k]), 32'h1);
      return;
    end
    last_acc = cyc + 1;
    model(k, w, a, d, s, want_rsp, ed, ee);
    if (want_rsp) begin
      e.dat  = ed;
      e.err  = ee;
      e.inst = 2'(k);
      e.cyc  = 32'(last_acc + 1 + ws_of(k));
      sbq.push_back(e);
      tagq.push_back(tag);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) cmd_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sbq.size()), 32'h0);
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          check_eq($sformatf("unexpected_rsp_inst%0d", k), 32'(rsp_valid[k]), 32'h0);
        end else begin
          sb_t   e;
          string t;
          e = sbq.pop_front();
          t = tagq.pop_front();
          check_eq({t, "_inst"}, 32'(k), 32'(e.inst));
          check_eq({t, "_data"}, rsp_data[k], e.dat);
          check_eq({t, "_err"}, 32'(rsp_error[k]), 32'(e.err));
          check_eq({t, "_cycle"}, 32'(cyc), e.cyc);
        end
      end else if (rst === 1'b0) begin
        check_eq($sformatf("idle_data_inst%0d", k), rsp_data[k], 32'h0);
        check_eq($sformatf("idle_err_inst%0d", k), 32'(rsp_error[k]), 32'h0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_wr[k]    = 1'b0;
      cmd_addr[k]  = 32'h0;
      cmd_data[k]  = 32'h0;
      cmd_size[k]  = 4'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_ready%0d", k), 32'(cmd_ready[k]), 32'h0);
      check_eq($sformatf("rst_valid%0d", k), 32'(rsp_valid[k]), 32'h0);
      check_eq($sformatf("rst_err%0d", k), 32'(rsp_error[k]), 32'h0);
      check_eq($sformatf("rst_data%0d", k), rsp_data[k], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("ready_after_rst%0d", k), 32'(cmd_ready[k]), 32'h1);

    // No wait states, 1024 words at address 0
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, "sw10");
    issue(0, 1'b0, 32'h10, 32'h0, 4'b1111, "lw10");
    check_eq("ready_gap_ws0", 32'(last_wait), 32'h1);
    issue(0, 1'b1, 32'h11, 32'h0000_00AA, 4'b0001, "sb11");
    issue(0, 1'b0, 32'h10, 32'h0, 4'b1111, "lw10_after_sb");
    issue(0, 1'b0, 32'h13, 32'h0, 4'b0001, "lbu13");
    issue(0, 1'b0, 32'h12, 32'h0, 4'b0011, "lhu12");
    issue(0, 1'b0, 32'h12, 32'h0, 4'b1111, "lw12_misaligned");
    issue(0, 1'b1, 32'h13, 32'h0000_1234, 4'b0011, "sh13_misaligned");
    issue(0, 1'b0, 32'h10, 32'h0, 4'b1111, "lw10_unchanged");
    issue(0, 1'b0, 32'h10, 32'h0, 4'b0111, "bad_size");
    issue(0, 1'b1, 32'h10, 32'h0, 4'b0000, "bad_size_wr");
    issue(0, 1'b0, 32'h1000, 32'h0, 4'b1111, "lw1000_range");
    issue(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'b1111, "swffc");
    issue(0, 1'b0, 32'hFFC, 32'h0, 4'b1111, "lwffc");
    issue(0, 1'b1, 32'h14, 32'h0102_0304, 4'b1111, "sw14");
    issue(0, 1'b1, 32'h16, 32'hFFFF_BEEF, 4'b0011, "sh16");
    issue(0, 1'b0, 32'h14, 32'h0, 4'b1111, "lw14");
    issue(0, 1'b0, 32'h15, 32'h0, 4'b0001, "lbu15");
    idle();
    drain();

    // Three wait states, base 0x1000_0000, valid held high throughout
    issue(1, 1'b1, 32'h1000_0000, 32'hA5A5_0F0F, 4'b1111, "ws3_sw0");
    a_prev = last_acc;
    issue(1, 1'b0, 32'h1000_0000, 32'h0, 4'b1111, "ws3_lw0");
    check_eq("ws3_accept_spacing", 32'(last_acc - a_prev), 32'd5);
    check_eq("ws3_ready_low", 32'(last_wait), 32'd4);
    a_prev = last_acc;
    issue(1, 1'b1, 32'h1000_0004, 32'h0, 4'b1111, "ws3_sw4");
    check_eq("ws3_accept_spacing2", 32'(last_acc - a_prev), 32'd5);
    issue(1, 1'b1, 32'h1000_0005, 32'h0000_0077, 4'b0001, "ws3_sb5");
    issue(1, 1'b0, 32'h1000_0004, 32'h0, 4'b1111, "ws3_lw4");
    issue(1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'b1111, "ws3_below_base");
    issue(1, 1'b0, 32'h1000_0400, 32'h0, 4'b1111, "ws3_above_top");
    issue(1, 1'b1, 32'h1000_03FC, 32'h1234_5678, 4'b1111, "ws3_sw_top");
    issue(1, 1'b0, 32'h1000_03FE, 32'h0, 4'b0011, "ws3_lh_top");
    idle();
    drain();

    // Two wait states: reset while a store is in flight
    issue(2, 1'b1, 32'h20, 32'h1122_3344, 4'b1111, "ws2_sw20");
    issue(2, 1'b1, 32'h20, 32'h55AA_55AA, 4'b1111, "ws2_sw20_dropped", 1'b0);
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(cmd_ready[2]), 32'h0);
    check_eq("midrst_valid", 32'(rsp_valid[2]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready_after", 32'(cmd_ready[2]), 32'h1);
    repeat (4) @(negedge clk);
    issue(2, 1'b0, 32'h20, 32'h0, 4'b1111, "ws2_lw20_old");
    issue(2, 1'b0, 32'h40, 32'h0, 4'b1111, "ws2_range");
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
